// File: rtl/key_press_gen.sv
// Push-button transmitter: drives an active-low key line with timed presses
// and gaps on request, reporting progress through a busy/done handshake.
module key_press_gen #(
  parameter int unsigned T10MS   = 500_000,
  parameter int unsigned T_SHORT = 5_000_000,
  parameter int unsigned T_LONG  = 100_000_000,
  parameter int unsigned T_GAP   = 5_000_000,
  parameter int unsigned CW      = 27
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iCall,
  input  logic       iLong,
  input  logic [3:0] iCount,
  output logic       KEY_OUT,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] SHORT_LAST = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);

  // Widths below the debounce minimum are legal and still produce exact counts;
  // this label only makes such a configuration visible in the elaborated hierarchy.
  if (T_SHORT < 2 * T10MS || T_GAP < 2 * T10MS) begin : g_below_debounce_min
  end

  state_t        state;
  logic [CW-1:0] counter;
  logic [CW-1:0] hold_last;
  logic [3:0]    remaining;

  // The terminal press count is latched as hold-1 so PRESS compares without a subtractor.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state     <= IDLE;
      counter   <= '0;
      hold_last <= '0;
      remaining <= '0;
      KEY_OUT   <= 1'b1;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iCall) begin
            hold_last <= iLong ? LONG_LAST : SHORT_LAST;
            remaining <= (iCount == 4'd0) ? 4'd1 : iCount;
            counter   <= '0;
            KEY_OUT   <= 1'b0;
            oBusy     <= 1'b1;
            state     <= PRESS;
          end
        end

        PRESS: begin
          if (counter == hold_last) begin
            counter <= '0;
            KEY_OUT <= 1'b1;
            state   <= GAP;
          end else begin
            counter <= counter + 1'b1;
          end
        end

        GAP: begin
          if (counter == GAP_LAST) begin
            counter   <= '0;
            remaining <= remaining - 4'd1;
            if (remaining > 4'd1) begin
              KEY_OUT <= 1'b0;
              state   <= PRESS;
            end else begin
              oDone <= 1'b1;
              state <= DONE;
            end
          end else begin
            counter <= counter + 1'b1;
          end
        end

        DONE: begin
          oDone <= 1'b0;
          oBusy <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          counter <= '0;
          KEY_OUT <= 1'b1;
          oBusy   <= 1'b0;
          oDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule
